// File: rtl/pipe_addsub.sv
// pipe_addsub -- pipelined WIDTH-bit adder/subtractor with valid/ready flow control.
//
// The carry chain is cut into STAGES slices of CHUNK = WIDTH/STAGES bits. Slice k is
// computed combinationally from stage k-1 registers and captured in stage k. Operands
// travel alongside as skew registers. Completed low result bits travel alongside as
// deskew registers, so every bit of a result appears at the output together.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth, 1..WIDTH
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin, sub)
//   sub                   0: a+b+cin   1: a-b-cin (computed as a + ~b + ~cin)
//   out_valid / out_ready result handshake (sum, cout, ovf)
//   cout                  raw carry out of the MSB (sub mode: 1 = no borrow)
//   ovf                   two's-complement signed overflow
module pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipe_addsub: WIDTH must be a non-zero multiple of STAGES");
        end
    endgenerate

    // Per-stage registers. b is stored already conditioned for the operation.
    logic             v_q [STAGES];
    logic             v_d [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic             ovf_q;
    logic             ovf_d;
    logic             adv;

    always_comb begin
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic [CHUNK:0]   t;
        int unsigned      p;

        adv   = !v_q[STAGES-1] || out_ready;
        ovf_d = ovf_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            // p is clamped so stage 0 never forms an out-of-range index.
            p = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                a_src = a;
                b_src = b ^ {WIDTH{sub}};
                c_src = cin ^ sub;
                s_src = '0;
                v_d[k] = in_valid;
            end else begin
                a_src = a_q[p];
                b_src = b_q[p];
                c_src = c_q[p];
                s_src = s_q[p];
                v_d[k] = v_q[p];
            end
            t = {1'b0, a_src[k*CHUNK +: CHUNK]} + {1'b0, b_src[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, c_src};
            s_src[k*CHUNK +: CHUNK] = t[CHUNK-1:0];
            a_d[k] = a_src;
            b_d[k] = b_src;
            s_d[k] = s_src;
            c_d[k] = t[CHUNK];
            if (k == STAGES - 1) begin
                // Carry into the MSB recovered from the MSB sum bit.
                ovf_d = (a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ s_src[WIDTH-1]) ^ t[CHUNK];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
module tb_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic [31:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b1, cout, ovf;

    logic        in_valid8 = 1'b0, in_ready8, out_valid8, cout8, ovf8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    logic [33:0] q[$];
    logic        held_v = 1'b0;
    logic [33:0] held_val = '0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipe_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(1'b0), .sub(1'b0), .out_valid(out_valid8),
        .out_ready(1'b1), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: {cout, ovf, sum}; overflow from operand/result sign rule.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        logic [31:0] yy;
        logic        c;
        logic [32:0] r;
        logic        o;
        yy = s ? ~y : y;
        c  = s ? ~ci : ci;
        r  = {1'b0, x} + {1'b0, yy} + {32'd0, c};
        o  = (x[31] == yy[31]) && (r[31] != x[31]);
        return {r[32], o, r[31:0]};
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_data", {30'd0, cout, ovf, sum}, {30'd0, held_val});
            end
            held_v   = out_valid && !out_ready;
            held_val = {cout, ovf, sum};
            if (out_valid && out_ready) begin
                chk("out_expected", {63'd0, q.size() != 0}, 64'd1);
                if (q.size() != 0) begin
                    chk("result", {30'd0, cout, ovf, sum}, {30'd0, q.pop_front()});
                    pops++;
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s, input logic [31:0] es,
                          input logic ec, input logic eo);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
        n = 0;
        while (n < 10) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n++;
            if (out_valid) break;
        end
        chk({tag, "_latency"}, 64'(n), 64'd4);
        chk({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
        chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
        chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
        @(posedge clk); #1;
    endtask

    initial begin
        int p0;
        int n;
        // Reset state
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed corner cases
        single("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        single("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        single("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        single("sub_brw",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);

        // Full-rate stream: exactly one result per cycle
        p0 = pops;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = $urandom; b = $urandom;
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("stream_count", 64'(pops - p0), 64'd100);
        chk("stream_empty", 64'(q.size()), 64'd0);

        // Random valid / backpressure
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(99) < 70);
            out_ready = ($urandom_range(99) >= 30);
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk); #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_idle", {63'd0, out_valid}, 64'd0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_sum", {32'd0, sum}, 64'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        p0 = pops;
        repeat (8) @(posedge clk);
        @(negedge clk); #1;
        chk("no_stale_pops", 64'(pops - p0), 64'd0);
        chk("no_stale_valid", {63'd0, out_valid}, 64'd0);

        // Post-reset operation still correct
        single("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

        // Single-stage 8-bit instance: latency 1
        chk("w8_rst_valid", {63'd0, out_valid8}, 64'd0);
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        chk("w8_in_ready", {63'd0, in_ready8}, 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("w8_latency1", {63'd0, out_valid8}, 64'd1);
        chk("w8_sum", {56'd0, sum8}, 64'd0);
        chk("w8_cout", {63'd0, cout8}, 64'd1);
        chk("w8_ovf", {63'd0, ovf8}, 64'd0);
        @(posedge clk); #1;
        chk("w8_done", {63'd0, out_valid8}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
